// File: rtl/minterm_sweep.sv
// Exhaustive truth-table sweep of a 4-input combinational function: drives each minterm,
// waits SETTLE cycles, samples func_out and compares it against a latched expected table.
module minterm_sweep #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        func_out,
  output logic [3:0]  sweep_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_cnt,
  output logic        match
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  mis_q, mis_d;
  logic        done_q, done_d;
  logic        match_q, match_d;
  logic        miss;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    mis_d   = mis_q;
    done_d  = done_q;
    match_d = match_q;
    miss    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          exp_d   = expected;
          table_d = '0;
          mis_d   = '0;
          done_d  = 1'b0;
          match_d = 1'b0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        table_d[idx_q] = func_out;
        miss           = func_out != exp_q[idx_q];
        mis_d          = mis_q + {4'b0000, miss};
        if (idx_q != 4'd15) begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          // match must reflect the increment made on this same final edge
          state_d = S_IDLE;
          done_d  = 1'b1;
          match_d = (mis_d == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mis_q   <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign sweep_in     = idx_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign truth_table  = table_q;
  assign mismatch_cnt = mis_q;
  assign match        = match_q;

endmodule

// File: doc/minterm_sweep.md
MINTERM_SWEEP -- requirements
Module: minterm_sweep

Interface
REQ-001 Parameter SETTLE, default 2, is the number of clk cycles (1..15) the block holds each input value before sampling the function output.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a full 16-minterm sweep; accepted only in IDLE.
REQ-005 expected  input  16  expected truth table; bit i = required output for minterm i.
REQ-006 func_out  input  1  output of the 4-input combinational function under test.
REQ-007 sweep_in  output  4  minterm index driven to the function's 4-bit input.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  sticky; set when a sweep completes, cleared on the next accepted start.
REQ-010 table  output  16  captured truth table; bit i = func_out sampled for minterm i.
REQ-011 mismatch_cnt  output  5  count of minterms where the captured bit differs from expected (0..16).
REQ-012 match  output  1  registered; high with done when mismatch_cnt==0.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SETTLE and SAMPLE.
REQ-014 In IDLE, start=1 at edge k SHALL cause the following after edge k:
- state=SETTLE
- busy=1
- sweep_in=0
- internal index=0
- settle counter=0
- table=0, mismatch_cnt=0, done=0, match=0
- expected latched into an internal register.
REQ-015 Changes on the expected input after the start edge SHALL have no effect on the sweep in progress.
REQ-016 In SETTLE, the counter SHALL increment each edge, and on the edge where counter==SETTLE-1 the state SHALL move to SAMPLE.
REQ-017 In SAMPLE, exactly one edge SHALL perform all of the following:
- table[index] <= func_out
- if func_out != latched expected[index], mismatch_cnt increments by 1
- if index<15: index, sweep_in <= index+1; counter <= 0; state <= SETTLE.
REQ-018 In SAMPLE with index==15, the edge SHALL also:
- set state=IDLE, busy=0, done=1
- set match = (final mismatch_cnt == 0), including the increment from that same edge.
REQ-019 Each minterm SHALL take SETTLE+1 cycles, so done rises after edge k+16*(SETTLE+1) (edge k+48 for SETTLE=2).
REQ-020 sweep_in SHALL hold the value for the current minterm stable for the entire SETTLE and SAMPLE period.
REQ-021 After done, sweep_in SHALL hold 15 and table, mismatch_cnt and match SHALL hold their values until the next accepted start.
REQ-022 start while in SETTLE or SAMPLE SHALL be ignored, including start asserted on the same edge that sets done.
REQ-023 start asserted on any edge after done is set SHALL be accepted per REQ-014.
REQ-024 mismatch_cnt SHALL never wrap; 16 is the maximum reachable value.
REQ-025 Index and counter arithmetic SHALL be unsigned; the index never exceeds 15.

Reset
REQ-026 rst_n=0 at an edge SHALL force the following after that edge, regardless of state, including mid-sweep:
- state=IDLE
- sweep_in=0, busy=0, done=0
- table=0, mismatch_cnt=0, match=0
- index=0, counter=0, latched expected=0.
REQ-027 While rst_n=0, start SHALL be ignored.
REQ-028 The first start accepted after reset deasserts SHALL begin a complete sweep from minterm 0.

Verification
REQ-029 Reset: hold rst_n=0 for 2 edges -> all outputs 0 and busy=0; release, with no start -> outputs stay 0.
REQ-030 Match: SETTLE=2, func_out=sweep_in[0], expected=16'hAAAA, pulse start -> sweep_in steps 0..15, 3 cycles each; done=1 exactly 48 edges after start; table=16'hAAAA; mismatch_cnt=0; match=1.
REQ-031 Mismatch: func_out tied 0, expected=16'h8001 -> table=16'h0000, mismatch_cnt=2, match=0, done=1.
REQ-032 Ignored inputs: during a sweep, pulse start at minterm 5 and change expected to 16'hFFFF -> sweep unaffected; results equal those of REQ-030.
REQ-033 Reset mid-sweep: assert rst_n=0 while sweep_in=7 -> all outputs 0 after that edge; a new start then completes a full 48-cycle sweep with correct results.
REQ-034 Back-to-back: start held high continuously -> start is ignored on the done edge; the next sweep begins one edge later, and done drops to 0 at that restart.
